// File: rtl/dest_reg_tracker_if.sv
// rtl/dest_reg_tracker_if.sv - Decode/forwarding bundle for the destination register tracker
// Purpose: groups the Decode-side inputs and the forwarding/stall outputs of dest_reg_tracker.
// Modports:
//   master - Decode control / forwarding unit side: drives Decode info, receives stage IDs and stall
//   slave  - dest_reg_tracker side
// Signals:
//   Rd_D/RegWrite_D/MemToReg_D  Decode destination, write enable, load flag
//   Rs1_D/Rs2_D/Use1_D/Use2_D   Decode source IDs and their read qualifiers
//   Valid_D, Flush_E, Mem_Ready Decode validity, branch flush into E, data memory completion
//   Rd_E/Rd_M/Rd_WB, En_M/En_WB stage destination IDs and forwardable qualifiers
//   Stall_FD, Stall_Cnt         Fetch/Decode stall request and saturating stall-cycle count
interface dest_reg_tracker_if #(
  parameter int N  = 4,
  parameter int CW = 16
);
  logic [N-1:0]  Rd_D;
  logic          RegWrite_D;
  logic          MemToReg_D;
  logic [N-1:0]  Rs1_D;
  logic [N-1:0]  Rs2_D;
  logic          Use1_D;
  logic          Use2_D;
  logic          Valid_D;
  logic          Flush_E;
  logic          Mem_Ready;
  logic [N-1:0]  Rd_E;
  logic [N-1:0]  Rd_M;
  logic [N-1:0]  Rd_WB;
  logic          En_M;
  logic          En_WB;
  logic          Stall_FD;
  logic [CW-1:0] Stall_Cnt;

  modport master (
    output Rd_D, RegWrite_D, MemToReg_D, Rs1_D, Rs2_D, Use1_D, Use2_D,
           Valid_D, Flush_E, Mem_Ready,
    input  Rd_E, Rd_M, Rd_WB, En_M, En_WB, Stall_FD, Stall_Cnt
  );

  modport slave (
    input  Rd_D, RegWrite_D, MemToReg_D, Rs1_D, Rs2_D, Use1_D, Use2_D,
           Valid_D, Flush_E, Mem_Ready,
    output Rd_E, Rd_M, Rd_WB, En_M, En_WB, Stall_FD, Stall_Cnt
  );
endinterface

// File: rtl/dest_reg_tracker.sv
// rtl/dest_reg_tracker.sv - E/M/WB destination register tracking with load-use and memory-wait stall
// Purpose: tracks {valid, rd, write, load} for the Execute, Memory and Write-Back stages, feeds the
//   forwarding unit, and raises the Fetch/Decode stall plus Execute bubble on load-use or memory wait.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset; all stages become bubbles, stall counter cleared
//   bus   - dest_reg_tracker_if.slave: Decode inputs, stage IDs, enables, stall and stall count
module dest_reg_tracker #(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dest_reg_tracker_if.slave bus
);

  logic          r_v_e, r_we_e, r_ld_e;
  logic [N-1:0]  r_rd_e;
  logic          r_v_m, r_we_m, r_ld_m;
  logic [N-1:0]  r_rd_m;
  logic          r_v_w, r_we_w;
  logic [N-1:0]  r_rd_w;
  logic [CW-1:0] r_stall_cnt;

  logic w_load_use;
  logic w_freeze;
  logic w_stall;
  logic w_bubble_e;

  // A load in E whose destination is actually read by the Decode instruction.
  assign w_load_use = r_v_e & r_ld_e & r_we_e & bus.Valid_D &
                      ((bus.Use1_D & (bus.Rs1_D == r_rd_e)) |
                       (bus.Use2_D & (bus.Rs2_D == r_rd_e)));
  assign w_freeze   = r_v_m & r_ld_m & ~bus.Mem_Ready;
  assign w_stall    = w_load_use | w_freeze;
  assign w_bubble_e = bus.Flush_E | w_load_use | ~bus.Valid_D;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_e  <= 1'b0;
      r_we_e <= 1'b0;
      r_ld_e <= 1'b0;
      r_rd_e <= '0;
      r_v_m  <= 1'b0;
      r_we_m <= 1'b0;
      r_ld_m <= 1'b0;
      r_rd_m <= '0;
      r_v_w  <= 1'b0;
      r_we_w <= 1'b0;
      r_rd_w <= '0;
    end else if (w_freeze) begin
      // M and E hold; WB drains to a bubble. A flush still clears E.
      r_v_w  <= 1'b0;
      r_we_w <= 1'b0;
      r_rd_w <= '0;
      if (bus.Flush_E) begin
        r_v_e  <= 1'b0;
        r_we_e <= 1'b0;
        r_ld_e <= 1'b0;
        r_rd_e <= '0;
      end
    end else begin
      // Load flag is not needed past M: WB forwards loads and ALU results alike.
      r_v_w  <= r_v_m;
      r_we_w <= r_we_m;
      r_rd_w <= r_rd_m;
      r_v_m  <= r_v_e;
      r_we_m <= r_we_e;
      r_ld_m <= r_ld_e;
      r_rd_m <= r_rd_e;
      if (w_bubble_e) begin
        r_v_e  <= 1'b0;
        r_we_e <= 1'b0;
        r_ld_e <= 1'b0;
        r_rd_e <= '0;
      end else begin
        r_v_e  <= 1'b1;
        r_we_e <= bus.RegWrite_D;
        r_ld_e <= bus.MemToReg_D;
        r_rd_e <= bus.Rd_D;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.Rd_E      = r_rd_e;
  assign bus.Rd_M      = r_rd_m;
  assign bus.Rd_WB     = r_rd_w;
  assign bus.En_M      = r_v_m & r_we_m & ~r_ld_m;
  assign bus.En_WB     = r_v_w & r_we_w;
  assign bus.Stall_FD  = w_stall;
  assign bus.Stall_Cnt = r_stall_cnt;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// tb/tb_dest_reg_tracker.sv - directed self-checking bench for dest_reg_tracker
module tb_dest_reg_tracker;

  localparam int N  = 4;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  dest_reg_tracker_if #(.N(N), .CW(CW)) bus ();

  dest_reg_tracker #(.N(N), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic valid, input logic [N-1:0] rd, input logic we, input logic ld,
                         input logic [N-1:0] rs1, input logic use1,
                         input logic [N-1:0] rs2, input logic use2);
    bus.Valid_D    = valid;
    bus.Rd_D       = rd;
    bus.RegWrite_D = we;
    bus.MemToReg_D = ld;
    bus.Rs1_D      = rs1;
    bus.Use1_D     = use1;
    bus.Rs2_D      = rs2;
    bus.Use2_D     = use2;
    #1;
  endtask

  task automatic do_reset();
    drive_d(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    bus.Flush_E   = 1'b0;
    bus.Mem_Ready = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus.Flush_E   = 1'b0;
    bus.Mem_Ready = 1'b1;
    drive_d(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

    // Reset state
    check("rst_rd_e", bus.Rd_E, 0);
    check("rst_rd_m", bus.Rd_M, 0);
    check("rst_rd_wb", bus.Rd_WB, 0);
    check("rst_en_m", bus.En_M, 0);
    check("rst_en_wb", bus.En_WB, 0);
    check("rst_stall", bus.Stall_FD, 0);
    check("rst_cnt", bus.Stall_Cnt, 0);
    tick();
    rst_n = 1'b1;
    #1;

    // Three ALU writes r1, r2, r3
    for (int i = 1; i <= 3; i++) begin
      drive_d(1'b1, 4'(i), 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      check("alu_stall", bus.Stall_FD, 0);
      tick();
    end
    check("alu_rd_e", bus.Rd_E, 3);
    check("alu_rd_m", bus.Rd_M, 2);
    check("alu_rd_wb", bus.Rd_WB, 1);
    check("alu_en_m", bus.En_M, 1);
    check("alu_en_wb", bus.En_WB, 1);

    // Load r5 then consumer reading r5 via Rs1
    do_reset();
    drive_d(1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    drive_d(1'b1, 4'd6, 1'b1, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0);
    check("lu_stall_on", bus.Stall_FD, 1);
    tick();
    check("lu_bubble_rd_e", bus.Rd_E, 0);
    check("lu_load_in_m", bus.Rd_M, 5);
    check("lu_en_m_load", bus.En_M, 0);
    check("lu_stall_off", bus.Stall_FD, 0);
    check("lu_cnt", bus.Stall_Cnt, 1);
    tick();
    check("lu_cons_in_e", bus.Rd_E, 6);
    check("lu_load_in_wb", bus.Rd_WB, 5);
    check("lu_en_wb", bus.En_WB, 1);
    check("lu_cnt_hold", bus.Stall_Cnt, 1);

    // Load r5 then consumer with Rs2=5 but Use2=0
    do_reset();
    drive_d(1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    drive_d(1'b1, 4'd6, 1'b1, 1'b0, 4'd3, 1'b1, 4'd5, 1'b0);
    check("nouse_stall", bus.Stall_FD, 0);
    tick();
    check("nouse_rd_e", bus.Rd_E, 6);
    check("nouse_cnt", bus.Stall_Cnt, 0);

    // Register 0 is an ordinary ID; invalid Decode never stalls
    do_reset();
    drive_d(1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    drive_d(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0);
    check("r0_stall", bus.Stall_FD, 1);
    drive_d(1'b0, 4'd7, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0);
    check("invalid_d_stall", bus.Stall_FD, 0);

    // Memory wait: r4 ALU, load r5, ALU r7, then Mem_Ready=0 for 3 edges
    do_reset();
    drive_d(1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    drive_d(1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    drive_d(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    drive_d(1'b1, 4'd8, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    check("mw_pre_rd_wb", bus.Rd_WB, 4);
    check("mw_pre_en_wb", bus.En_WB, 1);
    bus.Mem_Ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("mw_stall", bus.Stall_FD, 1);
      tick();
      check("mw_rd_m", bus.Rd_M, 5);
      check("mw_rd_e", bus.Rd_E, 7);
      check("mw_en_wb", bus.En_WB, 0);
    end
    check("mw_cnt", bus.Stall_Cnt, 3);
    bus.Mem_Ready = 1'b1;
    #1;
    check("mw_release_stall", bus.Stall_FD, 0);
    tick();
    check("mw_adv_rd_wb", bus.Rd_WB, 5);
    check("mw_adv_en_wb", bus.En_WB, 1);
    check("mw_adv_rd_m", bus.Rd_M, 7);
    check("mw_adv_rd_e", bus.Rd_E, 8);
    check("mw_cnt_hold", bus.Stall_Cnt, 3);

    // Flush during freeze: E clears, M holds
    do_reset();
    drive_d(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    drive_d(1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    drive_d(1'b1, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    bus.Mem_Ready = 1'b0;
    bus.Flush_E   = 1'b1;
    #1;
    tick();
    check("fl_rd_e", bus.Rd_E, 0);
    check("fl_rd_m", bus.Rd_M, 5);
    bus.Flush_E = 1'b0;
    #1;

    // Saturation: keep the freeze for 2^CW+5 more edges
    for (int i = 0; i < (1 << CW) + 5; i++) tick();
    check("sat_cnt", bus.Stall_Cnt, 15);
    check("sat_stall", bus.Stall_FD, 1);
    check("sat_rd_m", bus.Rd_M, 5);

    // Asynchronous reset mid-freeze, away from any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_rd_e", bus.Rd_E, 0);
    check("ar_rd_m", bus.Rd_M, 0);
    check("ar_rd_wb", bus.Rd_WB, 0);
    check("ar_en_m", bus.En_M, 0);
    check("ar_en_wb", bus.En_WB, 0);
    check("ar_stall", bus.Stall_FD, 0);
    check("ar_cnt", bus.Stall_Cnt, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("ar_no_residual", bus.Stall_FD, 0);
    tick();
    check("ar_cnt_after", bus.Stall_Cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
